// File: rtl/seg7_scan_ctrl.sv
// Multiplexed BCD 7-segment scanner: one shared decoder, one-hot digit enables, guard cycle per slot.
// Latency: an/seg follow cnt/idx/disp directly; a loaded value shows from cycle 1 of the frame after the next boundary.
// Backpressure: rdy drops while a value is pending; a load with rdy low is dropped, and ack pulses when the value is applied.
module seg7_scan_ctrl #(
    parameter int NDIG = 4,
    parameter int DIV  = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*NDIG-1:0]   din,
    input  logic                lz_en,
    output logic                rdy,
    output logic                ack,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          seg
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    generate
        if (NDIG < 1 || NDIG > 8 || DIV < 2) begin : g_bad_params
            $error("seg7_scan_ctrl: NDIG must be 1..8 and DIV at least 2");
        end
    endgenerate

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic [4*NDIG-1:0]   pend_q;
    logic                pvalid_q;
    logic [4*NDIG-1:0]   disp_q;
    logic                ack_q;
    logic                lz_q;

    logic                cnt_wrap;
    logic                fb;
    logic                apply;
    logic [3:0]          cur_dig;
    logic [IW-1:0]       msd;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b1111110;
            4'd1:    dec7 = 7'b0110000;
            4'd2:    dec7 = 7'b1101101;
            4'd3:    dec7 = 7'b1111001;
            4'd4:    dec7 = 7'b0110011;
            4'd5:    dec7 = 7'b1011011;
            4'd6:    dec7 = 7'b1011111;
            4'd7:    dec7 = 7'b1110000;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1111011;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign fb       = cnt_wrap && (idx_q == IDX_LAST);
    assign apply    = fb && pvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_wrap) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Apply takes priority; a load in the boundary cycle with an empty buffer
    // lands in pend and waits a full frame, since pvalid was still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pvalid_q <= 1'b0;
            disp_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= apply;
            if (apply) begin
                disp_q   <= pend_q;
                pvalid_q <= 1'b0;
            end else if (load && !pvalid_q) begin
                pend_q   <= din;
                pvalid_q <= 1'b1;
            end
        end
    end

    // lz_en is registered so no output has a combinational path from an input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q    <= 1'b0;
            state_q <= BLANK;
        end else begin
            lz_q    <= lz_en;
            state_q <= state_d;
        end
    end

    always_comb begin
        cur_dig = 4'd0;
        msd     = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                cur_dig = disp_q[4*k +: 4];
            end
            if (disp_q[4*k +: 4] != 4'd0) begin
                msd = IW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        an      = '0;
        seg     = '0;
        if (apply) begin
            state_d = SHOW;
        end
        if (state_q == SHOW && cnt_q != '0 && !(lz_q && idx_q > msd)) begin
            an  = NDIG'(1) << idx_q;
            seg = dec7(cur_dig);
        end
    end

    assign rdy = ~pvalid_q;
    assign ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=4 (16-cycle frames).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic        lz_en;
    logic        rdy;
    logic        ack;
    logic [3:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;
    int n      = 0;

    seg7_scan_ctrl #(.NDIG(4), .DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (din),
        .lz_en (lz_en),
        .rdy   (rdy),
        .ack   (ack),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Entered in the ack cycle (frame position 0); checks one full frame.
    task automatic frame_check(input string tag, input logic [3:0] lit,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] st [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int c, ix;
        st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
        chk({tag, "_phase"}, 32'(n % 16), 32'd0);
        for (int i = 0; i < 16; i++) begin
            c  = n % 4;
            ix = (n / 4) % 4;
            exp_an  = 4'd0;
            exp_seg = 7'd0;
            if (c != 0 && lit[ix]) begin
                exp_an  = 4'(1 << ix);
                exp_seg = st[ix];
            end
            chk($sformatf("%s_an_s%0d_c%0d", tag, ix, c), 32'(an), 32'(exp_an));
            chk($sformatf("%s_seg_s%0d_c%0d", tag, ix, c), 32'(seg), 32'(exp_seg));
            step();
        end
    endtask

    task automatic wait_ack(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (ack) got = 1'b1;
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        chk({tag, "_rdy_at_ack"}, 32'(rdy), 32'd1);
    endtask

    task automatic apply_val(input string tag, input logic [15:0] d, input logic lz);
        lz_en = lz;
        din   = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk({tag, "_rdy_low"}, 32'(rdy), 32'd0);
        wait_ack(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an_acc;
        logic       ack_acc;
        int         t0;

        rst_n = 1'b0;
        load  = 1'b0;
        din   = '0;
        lz_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        n = 0;

        an_acc = '0; ack_acc = 1'b0;
        repeat (48) begin
            step();
            an_acc  |= an;
            ack_acc |= ack;
        end
        chk("idle_an_blank", 32'(an_acc), 32'd0);
        chk("idle_no_ack", 32'(ack_acc), 32'd0);

        // Load 1234 at cnt=2 idx=0, then a dropped 5678 while pending.
        step(); step();
        din = 16'h1234; load = 1'b1;
        step();
        chk("l1_rdy_low", 32'(rdy), 32'd0);
        din = 16'h5678;
        step();
        load = 1'b0;
        chk("l1_rdy_still_low", 32'(rdy), 32'd0);
        for (int i = 0; i < 40 && !ack; i++) step();
        chk("l1_ack_cycle", 32'(n), 32'd64);
        chk("l1_rdy_at_ack", 32'(rdy), 32'd1);
        frame_check("f1234", 4'b1111, 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000);

        // Load accepted in the frame-boundary cycle waits a full frame.
        while (n % 16 != 15) step();
        din = 16'h5678; load = 1'b1; t0 = n;
        step();
        load = 1'b0;
        for (int i = 0; i < 40 && !ack; i++) step();
        chk("fb_load_ack_delay", 32'(n - t0), 32'd17);
        frame_check("f5678", 4'b1111, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011);

        apply_val("lz7", 16'h0007, 1'b1);
        frame_check("lz7", 4'b0001, 7'b1110000, 7'd0, 7'd0, 7'd0);
        apply_val("lz0", 16'h0000, 1'b1);
        frame_check("lz0", 4'b0001, 7'b1111110, 7'd0, 7'd0, 7'd0);
        apply_val("lzA", 16'h0A00, 1'b1);
        frame_check("lzA", 4'b0111, 7'b1111110, 7'b1111110, 7'b0000000, 7'd0);

        // Reset while a load is pending and the display is lit.
        lz_en = 1'b0;
        while (n % 16 != 5) step();
        din = 16'h4321; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("mid_rdy_low", 32'(rdy), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        an_acc = '0; ack_acc = 1'b0;
        repeat (40) begin
            step();
            an_acc  |= an;
            ack_acc |= ack;
        end
        chk("post_rst_an_blank", 32'(an_acc), 32'd0);
        chk("post_rst_no_ack", 32'(ack_acc), 32'd0);

        apply_val("f4321", 16'h4321, 1'b0);
        frame_check("f4321", 4'b1111, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Multiplexed scan controller for an NDIG-digit common-segment 7-segment display. It holds a frame of packed BCD digits and time-shares one internal BCD-to-7-segment decode path across all digits. It drives one-hot digit enables with a guard cycle between slots, so segment data never overlaps two digits. New display values are accepted through a ready/load handshake and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NDIG, 4: number of digits; legal range is 1–8.
- DIV, 1000: clock cycles per digit slot; minimum value is 2.
- clk  in  1  the single clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  load strobe for din; accepted only when rdy=1.
- din  in  4*NDIG  packed BCD digits; digit k is din[4k+3:4k], and digit 0 is least significant.
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- rdy  out  1  high when the pending buffer is empty and a load can be accepted.
- ack  out  1  one-cycle pulse when a pending value becomes the displayed value.
- an  out  NDIG  one-hot digit enable, active-high; an[k] drives digit k.
- seg  out  7  segment pattern {a,b,c,d,e,f,g}, active-high, with a at the MSB.

## Operation
- Registers:
  - cnt: slot cycle counter, 0..DIV-1.
  - idx: digit index, 0..NDIG-1.
  - pend, pvalid: pending buffer and its valid flag.
  - disp: displayed digits.
  - state: BLANK or SHOW.
- Counters:
  - cnt increments every cycle. It wraps from DIV-1 to 0.
  - On each wrap, idx increments mod NDIG.
  - Counters run in both states.
- Frame boundary (FB): the cycle with idx=NDIG-1 and cnt=DIV-1. A frame is NDIG*DIV cycles.
- Handshake:
  - rdy = ~pvalid.
  - When load=1 and rdy=1, pend<=din and pvalid<=1.
  - A load while rdy=0 is ignored and the data is dropped.
- Apply:
  - At FB with pvalid=1: disp<=pend, pvalid<=0, state<=SHOW.
  - ack=1 in the following cycle, which is the first cycle of the next frame.
  - If load is accepted in the FB cycle itself (pvalid was 0), the value waits for the next FB. There is no bypass.
- State BLANK:
  - Entered on reset; there is no exit except an apply.
  - an=0 and seg=0.
- State SHOW:
  - Guard cycle (cnt=0): an=0, seg=0.
  - cnt≥1: an=1<<idx and seg=dec(disp digit idx).
  - SHOW is never left except by reset.
- dec mapping:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011.
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Codes 10–15 give 0000000, but an is still asserted for that slot.
- Leading-zero blanking (lz_en=1):
  - Let m be the highest k with disp digit k ≠ 0, or m=0 if all digits are zero.
  - Slots with idx>m force an=0 and seg=0.
  - Digit 0 is always shown.
  - Invalid codes count as nonzero.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - cnt=0, idx=0, pvalid=0, pend=0, disp=0, state=BLANK.
  - rdy=1, ack=0, an=0, seg=0.
- Reset asserted mid-frame or mid-handshake aborts everything. The pending value is lost and the display blanks until the next apply.
- Output timing:
  - an, seg, rdy and ack are glitch-free functions of registers; no output depends combinationally on an input.
  - an and seg reflect the current cnt/idx/disp with no extra lag.
- Latency:
  - rdy falls the cycle after an accepted load.
  - The new value appears on an/seg at cycle 1 of the first frame after the next FB.
  - Worst case from load to ack is NDIG*DIV+1 cycles.
- rdy rises in the same cycle ack is high.
- lz_en changes take effect on the next slot evaluation; no synchronisation is required.

## Test plan
- Reset, NDIG=4, DIV=4:
  - While rst_n=0: an=0000, seg=0, rdy=1, ack=0.
  - After release: an stays 0 for 3 full frames with no load.
- Load din=16'h1234, lz_en=0, at cnt=2, idx=0:
  - rdy=0 on the next cycle.
  - ack pulses at the first cycle after FB.
  - Slot 0: guard cycle, then an=0001, seg=0110011 for 3 cycles.
  - Slots 1–3 show 3, 2, 1 (1111001, 1101101, 0110000).
  - Every slot has an=0 at cnt=0.
- Second load (16'h5678) while rdy=0:
  - It is ignored, and the display remains 1234.
  - A load accepted exactly at FB is applied one frame later, with ack 17 cycles after acceptance.
- Leading-zero blanking, lz_en=1:
  - din=16'h0007: only slot 0 lights (an=0001, seg=1110000); slots 1–3 have an=0.
  - din=16'h0000: only slot 0 shows 1111110.
  - din=16'h0A00: slots 2, 1 and 0 are lit, with slot 2 seg=0000000.
- Reset mid-frame after a load was accepted but not yet applied:
  - Outputs return immediately to reset values.
  - After release, the display stays blank with no ack.
  - A fresh load then works normally.
